// File: rtl/ccl_merge_resolver_if.sv
// Merge-request handshake and second-pass lookup port of the CCL equivalence resolver.
interface ccl_merge_resolver_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             merge_valid;
    logic             merge_ready;
    logic [WIDTH-1:0] merge_max;
    logic [WIDTH-1:0] merge_min;
    logic             lookup_en;
    logic [WIDTH-1:0] lookup_label;
    logic [WIDTH-1:0] lookup_q;
    logic             lookup_q_valid;

    modport master (
        output merge_valid, merge_max, merge_min, lookup_en, lookup_label,
        input  merge_ready, lookup_q, lookup_q_valid
    );

    modport slave (
        input  merge_valid, merge_max, merge_min, lookup_en, lookup_label,
        output merge_ready, lookup_q, lookup_q_valid
    );
endinterface

// File: rtl/ccl_merge_resolver.sv
// Label equivalence manager: allocates labels, links class roots on merge requests,
// flattens the table at end of frame and serves registered root lookups.
module ccl_merge_resolver #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_start,
    input  logic                frame_end,
    input  logic                new_label,
    output logic [WIDTH-1:0]    label_count,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    ccl_merge_resolver_if.slave bus
);

    localparam logic [WIDTH-1:0] LcMax = WIDTH'(DEPTH - 1);
    localparam logic [WIDTH-1:0] One   = WIDTH'(1);

    typedef enum logic [1:0] {StCollect, StChase, StFlatten, StResolved} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_table [DEPTH];
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_idx;
    logic [WIDTH-1:0] r_label_count;
    logic             r_pending;
    logic             r_overflow;
    logic             r_done;
    logic [WIDTH-1:0] r_lookup_q;
    logic             r_lookup_q_valid;

    logic [WIDTH-1:0] w_ta;
    logic [WIDTH-1:0] w_tb;
    logic             w_roots;
    logic             w_merge_ok;
    logic             w_alloc;
    logic             w_link;
    logic [WIDTH-1:0] w_link_hi;
    logic [WIDTH-1:0] w_link_lo;
    logic [WIDTH-1:0] w_fl_cur;
    logic [WIDTH-1:0] w_fl_val;
    logic             w_fl_last;
    logic             w_fl_wr;
    logic             w_lookup_hit;

    always_comb begin
        w_ta         = r_table[r_ra];
        w_tb         = r_table[r_rb];
        w_roots      = (w_ta == r_ra) && (w_tb == r_rb);
        w_merge_ok   = bus.merge_valid && (r_state == StCollect)
                       && (bus.merge_max != '0) && (bus.merge_min != '0)
                       && (bus.merge_max < r_label_count) && (bus.merge_min < r_label_count)
                       && (bus.merge_max != bus.merge_min);
        w_alloc      = new_label && !frame_start && (r_state != StResolved)
                       && (r_label_count != LcMax);
        w_link       = (r_state == StChase) && w_roots && (r_ra != r_rb) && !frame_start;
        w_link_hi    = (r_ra > r_rb) ? r_ra : r_rb;
        w_link_lo    = (r_ra > r_rb) ? r_rb : r_ra;
        w_fl_cur     = r_table[r_idx];
        w_fl_val     = r_table[w_fl_cur];
        w_fl_last    = (r_idx == r_label_count - One);
        w_fl_wr      = (r_state == StFlatten) && !frame_start;
        w_lookup_hit = (bus.lookup_label != '0) && (bus.lookup_label < r_label_count);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StCollect;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; frame_start overrides everything
    always_comb begin
        w_state_next = r_state;
        if (frame_start) begin
            w_state_next = StCollect;
        end else begin
            unique case (r_state)
                StCollect: begin
                    if (frame_end) begin
                        w_state_next = (r_label_count == One) ? StResolved : StFlatten;
                    end else if (w_merge_ok) begin
                        w_state_next = StChase;
                    end
                end
                StChase: begin
                    if (w_roots) begin
                        w_state_next = (r_pending || frame_end) ? StFlatten : StCollect;
                    end
                end
                StFlatten: begin
                    if (w_fl_last) begin
                        w_state_next = StResolved;
                    end
                end
                StResolved: w_state_next = StResolved;
                default:    w_state_next = StCollect;
            endcase
        end
    end

    // Output logic
    always_comb begin
        bus.merge_ready    = (r_state == StCollect);
        busy               = (r_state == StChase) || (r_state == StFlatten);
        done               = r_done;
        overflow           = r_overflow;
        label_count        = r_label_count;
        bus.lookup_q       = r_lookup_q;
        bus.lookup_q_valid = r_lookup_q_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ra             <= '0;
            r_rb             <= '0;
            r_idx            <= '0;
            r_label_count    <= One;
            r_pending        <= 1'b0;
            r_overflow       <= 1'b0;
            r_done           <= 1'b0;
            r_lookup_q       <= '0;
            r_lookup_q_valid <= 1'b0;
        end else begin
            if (frame_start) begin
                r_label_count <= One;
                r_overflow    <= 1'b0;
            end else if (new_label && (r_state != StResolved)) begin
                if (r_label_count == LcMax) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_label_count <= r_label_count + One;
                end
            end

            r_pending <= (r_state == StChase) && (w_state_next == StChase)
                         && (r_pending || frame_end);

            if (w_merge_ok && (w_state_next == StChase)) begin
                r_ra <= bus.merge_max;
                r_rb <= bus.merge_min;
            end else if (r_state == StChase) begin
                r_ra <= w_ta;
                r_rb <= w_tb;
            end

            if ((w_state_next == StFlatten) && (r_state != StFlatten)) begin
                r_idx <= One;
            end else if (r_state == StFlatten) begin
                r_idx <= r_idx + One;
            end

            r_done <= (w_state_next == StResolved) && (r_state != StResolved);

            if ((r_state == StResolved) && bus.lookup_en) begin
                r_lookup_q       <= w_lookup_hit ? r_table[bus.lookup_label] : '0;
                r_lookup_q_valid <= 1'b1;
            end else begin
                r_lookup_q_valid <= 1'b0;
            end
        end
    end

    // Allocation never collides with a link or flatten write: those touch labels < label_count
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_table[r_label_count] <= r_label_count;
        end
        if (w_link) begin
            r_table[w_link_hi] <= w_link_lo;
        end
        if (w_fl_wr) begin
            r_table[r_idx] <= w_fl_val;
        end
    end

endmodule

// File: tb/tb_ccl_merge_resolver.sv
// Directed bench for ccl_merge_resolver: allocation, merges, flatten, lookups, overflow, aborts.
module tb_ccl_merge_resolver;

    logic       clk;
    logic       reset_n;
    logic       frame_start;
    logic       frame_end;
    logic       new_label;
    logic [7:0] label_count;
    logic       busy;
    logic       done;
    logic       overflow;

    int n_err;
    int n_checks;
    int cnt;
    logic seen;

    ccl_merge_resolver_if #(.WIDTH(8)) bus ();

    ccl_merge_resolver #(
        .WIDTH(8),
        .DEPTH(256)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .new_label   (new_label),
        .label_count (label_count),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic alloc(input int n);
        new_label = 1'b1;
        for (int i = 0; i < n; i++) step();
        new_label = 1'b0;
    endtask

    // Drive one merge and count cycles with merge_ready low afterwards
    task automatic merge_wait(input logic [7:0] mx, input logic [7:0] mn, output int low);
        bus.merge_valid = 1'b1;
        bus.merge_max   = mx;
        bus.merge_min   = mn;
        step();
        bus.merge_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.merge_ready) break;
            low++;
            step();
        end
    endtask

    task automatic wait_done(output int busy_cycles, output logic got);
        busy_cycles = 0;
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            step();
        end
    endtask

    task automatic end_frame(input string tag, input int exp_cycles);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        wait_done(cnt, seen);
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_flatten_cycles"}, cnt, exp_cycles);
    endtask

    task automatic lookup(input string tag, input logic [7:0] lbl, input logic [7:0] exp);
        bus.lookup_en    = 1'b1;
        bus.lookup_label = lbl;
        step();
        chk({tag, "_valid"}, 32'(bus.lookup_q_valid), 32'd1);
        chk({tag, "_q"}, 32'(bus.lookup_q), 32'(exp));
    endtask

    initial begin
        n_err = 0;
        n_checks = 0;
        reset_n = 1'b1;
        frame_start = 1'b0;
        frame_end = 1'b0;
        new_label = 1'b0;
        bus.merge_valid = 1'b0;
        bus.merge_max = '0;
        bus.merge_min = '0;
        bus.lookup_en = 1'b0;
        bus.lookup_label = '0;
        #3 reset_n = 1'b0;
        #10;
        chk("rst_label_count", 32'(label_count), 32'd1);
        chk("rst_merge_ready", 32'(bus.merge_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_lookup_q", 32'(bus.lookup_q), 32'd0);
        chk("rst_lookup_valid", 32'(bus.lookup_q_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Three singleton labels
        alloc(3);
        chk("t1_label_count", 32'(label_count), 32'd4);
        chk("t1_lookup_ignored", 32'(bus.lookup_q_valid), 32'd0);
        end_frame("t1", 3);
        step();
        chk("t1_done_pulse", 32'(done), 32'd0);
        lookup("t1_l1", 8'd1, 8'd1);
        lookup("t1_l2", 8'd2, 8'd2);
        lookup("t1_l3", 8'd3, 8'd3);
        lookup("t1_l0", 8'd0, 8'd0);
        lookup("t1_l5", 8'd5, 8'd0);
        bus.lookup_en = 1'b0;
        step();
        chk("t1_valid_drop", 32'(bus.lookup_q_valid), 32'd0);

        // Two pairs, then join them via a chain
        pulse_frame_start();
        chk("t2_label_count_reset", 32'(label_count), 32'd1);
        alloc(4);
        merge_wait(8'd2, 8'd1, cnt);
        chk("t2_m21_low", cnt, 1);
        merge_wait(8'd4, 8'd3, cnt);
        chk("t2_m43_low", cnt, 1);
        merge_wait(8'd4, 8'd2, cnt);
        chk("t2_m42_low", cnt, 2);
        end_frame("t2", 4);
        for (int i = 1; i <= 4; i++) lookup("t2_l", 8'(i), 8'd1);
        bus.lookup_en = 1'b0;

        // Invalid merges are dropped
        pulse_frame_start();
        alloc(3);
        bus.merge_valid = 1'b1;
        bus.merge_max = 8'd5; bus.merge_min = 8'd2;
        step();
        chk("t3_drop_range", 32'(bus.merge_ready), 32'd1);
        bus.merge_max = 8'd3; bus.merge_min = 8'd3;
        step();
        chk("t3_drop_equal", 32'(bus.merge_ready), 32'd1);
        bus.merge_max = 8'd0; bus.merge_min = 8'd1;
        step();
        chk("t3_drop_zero", 32'(bus.merge_ready), 32'd1);
        bus.merge_valid = 1'b0;
        end_frame("t3", 3);
        lookup("t3_l3", 8'd3, 8'd3);
        lookup("t3_l2", 8'd2, 8'd2);
        bus.lookup_en = 1'b0;

        // new_label in the link cycle
        pulse_frame_start();
        alloc(2);
        bus.merge_valid = 1'b1;
        bus.merge_max = 8'd2; bus.merge_min = 8'd1;
        step();
        bus.merge_valid = 1'b0;
        new_label = 1'b1;
        step();
        new_label = 1'b0;
        chk("t4_label_count", 32'(label_count), 32'd4);
        chk("t4_ready", 32'(bus.merge_ready), 32'd1);
        end_frame("t4", 3);
        lookup("t4_l1", 8'd1, 8'd1);
        lookup("t4_l2", 8'd2, 8'd1);
        lookup("t4_l3", 8'd3, 8'd3);
        bus.lookup_en = 1'b0;

        // frame_end during a two-hop chase
        pulse_frame_start();
        alloc(4);
        merge_wait(8'd2, 8'd1, cnt);
        merge_wait(8'd4, 8'd3, cnt);
        bus.merge_valid = 1'b1;
        bus.merge_max = 8'd4; bus.merge_min = 8'd2;
        step();
        bus.merge_valid = 1'b0;
        chk("t5_busy_chase", 32'(busy), 32'd1);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        wait_done(cnt, seen);
        chk("t5_done", 32'(seen), 32'd1);
        chk("t5_busy_cycles", cnt, 5);
        for (int i = 1; i <= 4; i++) lookup("t5_l", 8'(i), 8'd1);
        bus.lookup_en = 1'b0;

        // Overflow, then abort a flatten
        pulse_frame_start();
        alloc(254);
        chk("t6_label_count_full", 32'(label_count), 32'd255);
        chk("t6_no_overflow", 32'(overflow), 32'd0);
        alloc(1);
        chk("t6_overflow", 32'(overflow), 32'd1);
        chk("t6_label_count_hold", 32'(label_count), 32'd255);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t6_busy_flatten", 32'(busy), 32'd1);
        pulse_frame_start();
        chk("t6_abort_label_count", 32'(label_count), 32'd1);
        chk("t6_abort_overflow", 32'(overflow), 32'd0);
        chk("t6_abort_busy", 32'(busy), 32'd0);
        chk("t6_abort_ready", 32'(bus.merge_ready), 32'd1);

        // Asynchronous reset mid-chase
        alloc(3);
        merge_wait(8'd2, 8'd1, cnt);
        bus.merge_valid = 1'b1;
        bus.merge_max = 8'd3; bus.merge_min = 8'd2;
        step();
        bus.merge_valid = 1'b0;
        chk("t7_busy_chase", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t7_rst_label_count", 32'(label_count), 32'd1);
        chk("t7_rst_ready", 32'(bus.merge_ready), 32'd1);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_done", 32'(done), 32'd0);
        chk("t7_rst_overflow", 32'(overflow), 32'd0);
        chk("t7_rst_lookup_valid", 32'(bus.lookup_q_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Empty frame resolves immediately; RESOLVED ignores new_label
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        chk("t8_done_immediate", 32'(done), 32'd1);
        chk("t8_busy", 32'(busy), 32'd0);
        new_label = 1'b1;
        step();
        new_label = 1'b0;
        chk("t8_label_count_held", 32'(label_count), 32'd1);
        chk("t8_done_low", 32'(done), 32'd0);
        lookup("t8_l1", 8'd1, 8'd0);
        bus.lookup_en = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
